// File: rtl/imem_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, its two requesters and the memory macro.
// The slave modport is the arbiter's view; master is the environment (fetch, loader, memory).
interface imem_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) ();
    logic              f_req;
    logic [31:0]       f_pc;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_lock;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [DATA_W-1:0] m_din;
    logic [DATA_W-1:0] m_dout;

    modport slave (
        input  f_req, f_pc, l_req, l_we, l_addr, l_wdata, l_lock, m_dout,
        output f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata,
               m_addr, m_we, m_din
    );

    modport master (
        output f_req, f_pc, l_req, l_we, l_addr, l_wdata, l_lock, m_dout,
        input  f_gnt, f_rvalid, f_rdata, f_err, l_gnt, l_rvalid, l_rdata,
               m_addr, m_we, m_din
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory arbiter: round-robin fetch/loader with a loader lock mode.
// Optional stall counters are enabled by defining IMEM_ARB_PERF_EN.
module imem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic        clock,
    input  logic        reset,
    imem_arbiter_if.slave bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0] f_stall_cnt,
    output logic [31:0] l_stall_cnt
`endif
);

    localparam logic [0:0] ST_RR      = 1'b0;
    localparam logic [0:0] ST_LOCK    = 1'b1;
    localparam logic       OWN_FETCH  = 1'b0;
    localparam logic       OWN_LOADER = 1'b1;

    logic [0:0] r_state;
    logic       r_last_owner;
    logic       r_f_pend;
    logic       r_f_err;
    logic       r_l_pend;

    logic       w_f_err;
    logic       w_f_gnt;
    logic       w_l_gnt;

    assign w_f_err = (bus.f_pc[1:0] != 2'b00) || (bus.f_pc[31:ADDR_W+2] != '0);

    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (r_state == ST_LOCK) begin
            w_l_gnt = bus.l_req;
        end else if (bus.f_req && bus.l_req) begin
            w_f_gnt = (r_last_owner == OWN_LOADER);
            w_l_gnt = (r_last_owner == OWN_FETCH);
        end else begin
            w_f_gnt = bus.f_req;
            w_l_gnt = bus.l_req;
        end
    end

    // Errored fetches are consumed but leave the memory port idle.
    always_comb begin
        bus.m_addr = '0;
        bus.m_we   = 1'b0;
        bus.m_din  = '0;
        if (w_f_gnt) begin
            if (!w_f_err) begin
                bus.m_addr = bus.f_pc[ADDR_W+1:2];
            end
        end else if (w_l_gnt) begin
            bus.m_addr = bus.l_addr;
            bus.m_we   = bus.l_we;
            bus.m_din  = bus.l_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_RR;
            r_last_owner <= OWN_LOADER;
            r_f_pend     <= 1'b0;
            r_f_err      <= 1'b0;
            r_l_pend     <= 1'b0;
        end else begin
            r_state <= bus.l_lock ? ST_LOCK : ST_RR;
            if (r_state == ST_LOCK && !bus.l_lock) begin
                r_last_owner <= OWN_LOADER;
            end else if (w_f_gnt) begin
                r_last_owner <= OWN_FETCH;
            end else if (w_l_gnt) begin
                r_last_owner <= OWN_LOADER;
            end
            r_f_pend <= w_f_gnt;
            r_f_err  <= w_f_gnt && w_f_err;
            r_l_pend <= w_l_gnt && !bus.l_we;
        end
    end

    assign bus.f_gnt    = w_f_gnt;
    assign bus.l_gnt    = w_l_gnt;
    assign bus.f_rvalid = r_f_pend;
    assign bus.f_err    = r_f_err;
    assign bus.f_rdata  = (r_f_pend && !r_f_err) ? bus.m_dout : '0;
    assign bus.l_rvalid = r_l_pend;
    assign bus.l_rdata  = r_l_pend ? bus.m_dout : '0;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] r_f_stall_cnt;
    logic [31:0] r_l_stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_f_stall_cnt <= '0;
            r_l_stall_cnt <= '0;
        end else begin
            if (bus.f_req && !w_f_gnt && r_f_stall_cnt != '1) begin
                r_f_stall_cnt <= r_f_stall_cnt + 32'd1;
            end
            if (bus.l_req && !w_l_gnt && r_l_stall_cnt != '1) begin
                r_l_stall_cnt <= r_l_stall_cnt + 32'd1;
            end
        end
    end

    assign f_stall_cnt = r_f_stall_cnt;
    assign l_stall_cnt = r_l_stall_cnt;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model with a shadow copy of the instruction memory.
module tb_imem_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst;
    logic preload;

    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] f_stall_cnt;
    logic [31:0] l_stall_cnt;
`endif

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
`ifdef IMEM_ARB_PERF_EN
        ,
        .f_stall_cnt (f_stall_cnt),
        .l_stall_cnt (l_stall_cnt)
`endif
    );

    // Memory macro: registered read, write on m_we.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i) + 32'h100;
        end else if (bus.m_we) begin
            mem[bus.m_addr] <= bus.m_din;
        end
        bus.m_dout <= mem[bus.m_addr];
    end

    // Reference model state
    logic [31:0] ref_mem [DEPTH];
    bit          m_lock;
    bit          m_last_ldr;
    bit          fg, lg;
    logic [31:0] m_fst, m_lst;
    int          n_tests, n_fail;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        bit          perr;
        int          widx;
        logic [31:0] ea, ewe, ed;
        bit          nfv, nfe, nlv;
        logic [31:0] nfd, nld;
        #1;
        perr = (bus.f_pc % 4 != 0) || (bus.f_pc >= 32'(DEPTH * 4));
        widx = int'(bus.f_pc / 4);
        if (m_lock) begin
            fg = 1'b0;
            lg = bus.l_req;
        end else if (bus.f_req && bus.l_req) begin
            fg = m_last_ldr;
            lg = !m_last_ldr;
        end else begin
            fg = bus.f_req;
            lg = bus.l_req;
        end
        ea = 0; ewe = 0; ed = 0;
        if (fg) begin
            if (!perr) ea = 32'(widx);
        end else if (lg) begin
            ea = 32'(bus.l_addr);
            ewe = 32'(bus.l_we);
            ed = bus.l_wdata;
        end
        chk("f_gnt", 32'(bus.f_gnt), 32'(fg));
        chk("l_gnt", 32'(bus.l_gnt), 32'(lg));
        chk("m_addr", 32'(bus.m_addr), ea);
        chk("m_we", 32'(bus.m_we), ewe);
        chk("m_din", bus.m_din, ed);

        nfv = fg;
        nfe = fg && perr;
        nfd = (fg && !perr) ? ref_mem[widx] : 32'h0;
        nlv = lg && !bus.l_we;
        nld = nlv ? ref_mem[bus.l_addr] : 32'h0;
        if (lg && bus.l_we) ref_mem[bus.l_addr] = bus.l_wdata;

        if (rst) begin
            m_fst = 0;
            m_lst = 0;
            nfv = 0; nfe = 0; nlv = 0; nfd = 0; nld = 0;
            m_lock = 0;
            m_last_ldr = 1;
        end else begin
            if (bus.f_req && !fg && m_fst != 32'hFFFF_FFFF) m_fst++;
            if (bus.l_req && !lg && m_lst != 32'hFFFF_FFFF) m_lst++;
            if (m_lock && !bus.l_lock) m_last_ldr = 1;
            else if (fg) m_last_ldr = 0;
            else if (lg) m_last_ldr = 1;
            m_lock = bus.l_lock;
        end

        @(posedge clk);
        #1;
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(nfv));
        chk("f_err", 32'(bus.f_err), 32'(nfe));
        chk("f_rdata", bus.f_rdata, nfd);
        chk("l_rvalid", 32'(bus.l_rvalid), 32'(nlv));
        chk("l_rdata", bus.l_rdata, nld);
`ifdef IMEM_ARB_PERF_EN
        chk("f_stall_cnt", f_stall_cnt, m_fst);
        chk("l_stall_cnt", l_stall_cnt, m_lst);
`endif
    endtask

    task automatic drive(input bit freq, input logic [31:0] pc, input bit lreq, input bit we,
                         input logic [ADDR_W-1:0] addr, input logic [31:0] wd, input bit lock);
        bus.f_req   = freq;
        bus.f_pc    = pc;
        bus.l_req   = lreq;
        bus.l_we    = we;
        bus.l_addr  = addr;
        bus.l_wdata = wd;
        bus.l_lock  = lock;
    endtask

    task automatic idle(input bit lock);
        drive(0, 32'h0, 0, 0, '0, 32'h0, lock);
    endtask

    task automatic do_reset();
        rst = 1;
        idle(0);
        step();
        rst = 0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i) + 32'h100;
        m_lock = 0;
        m_last_ldr = 1;
        m_fst = 0;
        m_lst = 0;
        fg = 0;
        lg = 0;

        rst = 1;
        preload = 1;
        idle(0);
        step();
        preload = 0;
        do_reset();

        // Fetch only, consecutive words
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'(i * 4), 0, 0, '0, 32'h0, 0);
            step();
        end
        idle(0);
        step();

        // Contention straight after reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h10, 1, 0, 14'd5, 32'h0, 0);
            step();
        end
        idle(0);
        step();

        // Lock: loader writes while fetch is held off
        do_reset();
        idle(1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'hC, 1, 1, 14'd3, 32'hDEAD_BEEF, 1);
            step();
        end
        drive(1, 32'hC, 0, 0, '0, 32'h0, 0);
        step();
        drive(1, 32'hC, 1, 0, 14'd3, 32'h0, 0);
        step();
        drive(0, 32'h0, 1, 0, 14'd3, 32'h0, 0);
        step();
        idle(0);
        step();

        // Error and boundary fetch addresses
        drive(1, 32'h0000_0002, 0, 0, '0, 32'h0, 0);
        step();
        drive(1, 32'h0001_0000, 0, 0, '0, 32'h0, 0);
        step();
        drive(1, 32'h0000_FFFC, 0, 0, '0, 32'h0, 0);
        step();
        drive(1, 32'h8000_0000, 0, 0, '0, 32'h0, 0);
        step();
        idle(0);
        step();

        // Reset in the cycle a fetch is granted
        rst = 1;
        drive(1, 32'h20, 0, 0, '0, 32'h0, 0);
        step();
        rst = 0;
        drive(1, 32'h24, 1, 0, 14'd7, 32'h0, 0);
        step();
        drive(0, 32'h0, 1, 0, 14'd7, 32'h0, 0);
        step();
        idle(0);
        step();

        // Randomized traffic; requesters hold until granted
        for (int c = 0; c < 3000; c++) begin
            int unsigned r;
            rst = ($urandom % 250 == 0);
            if (!(bus.f_req && !fg)) begin
                bus.f_req = $urandom_range(0, 1) == 1;
                r = $urandom % 8;
                if (r == 0) bus.f_pc = {$urandom_range(0, 31), 2'b00} | 32'($urandom_range(1, 3));
                else if (r == 1) bus.f_pc = $urandom | 32'h0001_0000;
                else bus.f_pc = {$urandom_range(0, 31), 2'b00};
            end
            if (!(bus.l_req && !lg)) begin
                bus.l_req   = $urandom_range(0, 1) == 1;
                bus.l_we    = $urandom_range(0, 2) == 0;
                bus.l_addr  = ADDR_W'($urandom_range(0, 31));
                bus.l_wdata = $urandom;
            end
            if ($urandom % 16 == 0) bus.l_lock = !bus.l_lock;
            step();
        end
        rst = 0;
        idle(0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
